// File: rtl/blackbox_scan_pkg.sv
// blackbox_scan_pkg: shared state encoding and sizing for the blackbox truth-table scanner.
package blackbox_scan_pkg;
    localparam int NUM_VECTORS = 8;
    localparam int IDX_W = 3;
    localparam int CNT_W = 8;
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_SETTLE = 2'd1;
    localparam state_t ST_SAMPLE = 2'd2;
    localparam state_t ST_DONE = 2'd3;
endpackage

// File: rtl/first_diff_enc.sv
// first_diff_enc: flags any difference between two truth tables and encodes the lowest differing bit.
module first_diff_enc
    import blackbox_scan_pkg::*;
(
    input  logic [NUM_VECTORS-1:0] a_i,
    input  logic [NUM_VECTORS-1:0] b_i,
    output logic                   mismatch_o,
    output logic [IDX_W-1:0]       err_index_o
);
    logic [NUM_VECTORS-1:0] diff;
    assign diff = a_i ^ b_i;
    assign mismatch_o = |diff;
    // Descending scan so the lowest set bit is the last one to win.
    always_comb begin
        err_index_o = '0;
        for (int i = NUM_VECTORS - 1; i >= 0; i--)
            if (diff[i]) err_index_o = IDX_W'(i);
    end
endmodule

// File: rtl/blackbox_scanner.sv
// blackbox_scanner: steps {l,f,v} through all 8 vectors, samples w after a settle time, builds a truth table.
// Compare against expected_i is built only when BLACKBOX_SCAN_COMPARE_EN is defined.
module blackbox_scanner
    import blackbox_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [NUM_VECTORS-1:0] expected_i,
    input  logic                   w_i,
    output logic                   l_o,
    output logic                   f_o,
    output logic                   v_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [NUM_VECTORS-1:0] table_o,
    output logic                   mismatch_o,
    output logic [IDX_W-1:0]       err_index_o
);
    state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_VECTORS-1:0] table_q, table_d, table_s;
    logic mismatch_q, mismatch_d, cmp_mismatch;
    logic [IDX_W-1:0] err_q, err_d, cmp_err;
    logic accept, cnt_last, idx_last;
    assign accept = state_q == ST_IDLE && start_i;
    assign cnt_last = cnt_q == CNT_W'(SETTLE_CYCLES - 1);
    assign idx_last = idx_q == IDX_W'(NUM_VECTORS - 1);
    // Table as it will look after this SAMPLE; compare must see the final bit on DONE entry.
    assign table_s = (table_q & ~(NUM_VECTORS'(1) << idx_q)) | (NUM_VECTORS'(w_i) << idx_q);
`ifdef BLACKBOX_SCAN_COMPARE_EN
    logic [NUM_VECTORS-1:0] exp_q;
    always_ff @(posedge clk)
        if (reset) exp_q <= '0;
        else if (accept) exp_q <= expected_i;
    first_diff_enc u_enc (
        .a_i        (table_s),
        .b_i        (exp_q),
        .mismatch_o (cmp_mismatch),
        .err_index_o(cmp_err)
    );
`else
    logic unused_expected;
    assign unused_expected = ^expected_i;
    assign cmp_mismatch = 1'b0;
    assign cmp_err = '0;
`endif
    always_ff @(posedge clk)
        state_q <= reset ? ST_IDLE : state_d;
    always_comb
        state_d = (state_q == ST_IDLE)   ? (start_i  ? ST_SETTLE : ST_IDLE)   :
                  (state_q == ST_SETTLE) ? (cnt_last ? ST_SAMPLE : ST_SETTLE) :
                  (state_q == ST_SAMPLE) ? (idx_last ? ST_DONE   : ST_SETTLE) :
                                           ST_IDLE;
    always_comb begin
        busy_o = state_q == ST_SETTLE || state_q == ST_SAMPLE;
        done_o = state_q == ST_DONE;
    end
    always_comb begin
        idx_d = idx_q;
        cnt_d = cnt_q;
        table_d = table_q;
        mismatch_d = mismatch_q;
        err_d = err_q;
        if (accept) begin
            idx_d = '0;
            cnt_d = '0;
            table_d = '0;
            mismatch_d = 1'b0;
            err_d = '0;
        end
        if (state_q == ST_SETTLE) cnt_d = cnt_q + CNT_W'(1);
        if (state_q == ST_SAMPLE) begin
            table_d = table_s;
            idx_d = idx_last ? idx_q : idx_q + IDX_W'(1);
            cnt_d = '0;
            mismatch_d = idx_last ? cmp_mismatch : mismatch_q;
            err_d = idx_last ? cmp_err : err_q;
        end
    end
    always_ff @(posedge clk)
        if (reset) begin
            idx_q <= '0;
            cnt_q <= '0;
            table_q <= '0;
            mismatch_q <= 1'b0;
            err_q <= '0;
        end else begin
            idx_q <= idx_d;
            cnt_q <= cnt_d;
            table_q <= table_d;
            mismatch_q <= mismatch_d;
            err_q <= err_d;
        end
    assign {l_o, f_o, v_o} = idx_q;
    assign table_o = table_q;
    assign mismatch_o = mismatch_q;
    assign err_index_o = err_q;
endmodule
